// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/ack memory port between fetch and data.
// Data wins over fetch, with a streak limit and a memory-side watchdog.
//
// Ports:
//   clock, reset_n           rising-edge clock, async active-low reset
//   if_req/if_addr           fetch request; if_ready/if_rdata completion
//   d_req/d_we/d_addr/
//   d_wdata/d_be             data request; d_ready/d_rdata completion
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be         registered memory request, held until mem_ack
//   mem_ack/mem_rdata        memory completion and read data
//   xfer_err                 pulses with the ready of a timed-out transfer
//   err_sticky               set on any timeout, cleared only by reset
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_ready,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_ready,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    xfer_err,
  output logic                    err_sticky
);

  localparam int BE_W = DATA_WIDTH / 8;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_IF = 2'd1;
  localparam logic [1:0] S_BUSY_D  = 2'd2;

  localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);
  localparam logic       WDOG_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] WDOG_LAST  = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]            r_state;
  logic [3:0]            r_streak;
  logic [7:0]            r_wdog;
  logic                  r_err_sticky;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [BE_W-1:0]       r_mem_be;

  logic w_busy;
  logic w_timeout;
  logic w_done;
  logic w_grant_d;

  assign w_busy    = (r_state != S_IDLE);
  // Gated by w_busy so a 1-cycle watchdog cannot fire while idle.
  assign w_timeout = w_busy & WDOG_EN & (r_wdog == WDOG_LAST);
  assign w_done    = w_busy & (mem_ack | w_timeout);
  // Data only yields once it has won MAX_STREAK times over a waiting fetch.
  assign w_grant_d = d_req & (!if_req | (r_streak < MAX_STREAK));

  assign mem_req    = w_busy;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_be     = r_mem_be;
  assign err_sticky = r_err_sticky;

  assign if_ready = (r_state == S_BUSY_IF) & (mem_ack | w_timeout);
  assign d_ready  = (r_state == S_BUSY_D) & (mem_ack | w_timeout);
  assign if_rdata = mem_ack ? mem_rdata : '0;
  assign d_rdata  = mem_ack ? mem_rdata : '0;
  // A coincident ack wins over the watchdog.
  assign xfer_err = w_timeout & !mem_ack;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_streak     <= '0;
      r_wdog       <= '0;
      r_err_sticky <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wdog <= '0;
          if (w_grant_d) begin
            r_state     <= S_BUSY_D;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_mem_be    <= d_be;
            r_streak    <= if_req ? r_streak + 4'd1 : 4'd0;
          end else if (if_req) begin
            r_state     <= S_BUSY_IF;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_be    <= '1;
            r_streak    <= '0;
          end
        end
        S_BUSY_IF, S_BUSY_D: begin
          if (w_done) begin
            r_state <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + 8'd1;
          end
          if (w_timeout && !mem_ack) begin
            r_err_sticky <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
// Drivers push expected responses; a monitor pops them on each ready.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock;
  logic          reset_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_be;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          xfer_err;
  logic          err_sticky;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MAX_DATA_STREAK(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .xfer_err(xfer_err),
    .err_sticky(err_sticky)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t qi[$];
  exp_t qd[$];

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] ref_mem[int unsigned];
  logic [31:0] slv_mem[int unsigned];

  int    fix_wait  = 1;
  bit    rand_wait = 1'b0;
  string glog      = "";

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
      input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memory model: acks on busy cycle wait+1, garbage rdata otherwise.
  initial begin : slave
    int n;
    int w;
    logic [31:0] a;
    n = 0;
    w = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (mem_req) begin
        n++;
        if (n == 1) w = rand_wait ? int'($urandom_range(0, 4)) : fix_wait;
        a = mem_addr;
        if (n == w + 1) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            slv_mem[a] = merge(slv_mem.exists(a) ? slv_mem[a] : init_word(a),
                               mem_wdata, mem_be);
            mem_rdata = '0;
          end else begin
            mem_rdata = slv_mem.exists(a) ? slv_mem[a] : init_word(a);
          end
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        n = 0;
        mem_ack = 1'b0;
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: one pop per ready pulse; also logs grant order.
  logic prev_req = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (mem_req && !prev_req) glog = {glog, (mem_addr < 32'h100) ? "I" : "D"};
    prev_req = mem_req;
    if (reset_n && if_ready) begin
      if (qi.size() == 0) chk("if_ready_unexpected", 1, 0);
      else begin
        e = qi.pop_front();
        chk("if_rdata", if_rdata, e.rdata);
        chk("if_xfer_err", 32'(xfer_err), 32'(e.err));
      end
    end
    if (reset_n && d_ready) begin
      if (qd.size() == 0) chk("d_ready_unexpected", 1, 0);
      else begin
        e = qd.pop_front();
        chk("d_rdata", d_rdata, e.rdata);
        chk("d_xfer_err", 32'(xfer_err), 32'(e.err));
      end
    end
  end

  task automatic f_xfer(input logic [31:0] a, output int busy,
                        output int bad);
    exp_t e;
    bit got;
    if_addr = a;
    if_req = 1'b1;
    e.rdata = ref_rd(a);
    e.err = 1'b0;
    qi.push_back(e);
    busy = 0;
    bad = 0;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clock);
      if (mem_req && mem_addr < 32'h100) begin
        busy++;
        if (mem_we !== 1'b0 || mem_addr !== a || mem_be !== 4'hF ||
            mem_wdata !== '0) bad++;
      end
      got = if_ready;
    end
    if (!got) chk("if_wait_bound", 0, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic d_xfer(input logic we, input logic [31:0] a,
      input logic [31:0] wd, input logic [3:0] be, input bit xerr,
      output int busy, output int bad);
    exp_t e;
    bit got;
    d_we = we;
    d_addr = a;
    d_wdata = wd;
    d_be = be;
    d_req = 1'b1;
    e.err = xerr;
    e.rdata = (we || xerr) ? 32'h0 : ref_rd(a);
    if (we) ref_mem[a] = merge(ref_rd(a), wd, be);
    qd.push_back(e);
    busy = 0;
    bad = 0;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clock);
      if (mem_req && mem_addr >= 32'h100) begin
        busy++;
        if (mem_we !== we || mem_addr !== a || mem_be !== be ||
            mem_wdata !== wd) bad++;
      end
      got = d_ready;
    end
    if (!got) chk("d_wait_bound", 0, 1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_bound");
    $fatal(1);
  end

  initial begin : main
    int busy;
    int bad;
    reset_n = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    d_be = '0;
    ref_mem[32'h40] = 32'h8C22_0004;
    slv_mem[32'h40] = 32'h8C22_0004;

    repeat (3) @(negedge clock);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_fields", {mem_we, mem_be, mem_addr[26:0]}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ready_err", {if_ready, d_ready, xfer_err, err_sticky}, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // single fetch, ack one cycle after mem_req rises
    fix_wait = 1;
    f_xfer(32'h40, busy, bad);
    if_req = 1'b0;
    chk("fetch_busy_cycles", busy, 2);
    chk("fetch_mem_fields", bad, 0);

    // store with three wait cycles
    fix_wait = 3;
    d_xfer(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011, 1'b0, busy, bad);
    d_req = 1'b0;
    chk("store_busy_cycles", busy, 4);
    chk("store_mem_fields", bad, 0);

    // starvation guard with both requesters held
    fix_wait = 0;
    glog = "";
    fork
      begin
        int b1, x1;
        for (int k = 0; k < 8; k++)
          d_xfer(1'b0, 32'h104 + 32'(4 * k), '0, 4'hF, 1'b0, b1, x1);
        d_req = 1'b0;
      end
      begin
        int b2, x2;
        for (int k = 0; k < 2; k++)
          f_xfer(32'h80 + 32'(4 * k), b2, x2);
        if_req = 1'b0;
      end
    join
    chk("starve_order", (glog == "DDDDIDDDDI") ? 1 : 0, 1);
    if (glog != "DDDDIDDDDI") $display("  order was %s", glog);

    // watchdog abort on a load that is never acked
    fix_wait = 1000;
    d_xfer(1'b0, 32'h120, '0, 4'hF, 1'b1, busy, bad);
    d_req = 1'b0;
    chk("timeout_busy_cycles", busy, 8);
    chk("timeout_mem_req_drop", 32'(mem_req), 0);
    chk("timeout_sticky", 32'(err_sticky), 1);
    fix_wait = 1;
    f_xfer(32'h44, busy, bad);
    if_req = 1'b0;
    chk("post_timeout_fetch", busy, 2);
    chk("sticky_holds", 32'(err_sticky), 1);

    // async reset during a data grant; streak must restart at zero
    fix_wait = 3;
    glog = "";
    fork
      begin
        int b3, x3;
        for (int k = 0; k < 8; k++)
          d_xfer(1'b0, 32'h140 + 32'(4 * k), '0, 4'hF, 1'b0, b3, x3);
        d_req = 1'b0;
      end
      begin
        int b4, x4;
        f_xfer(32'hC0, b4, x4);
        if_req = 1'b0;
      end
      begin
        for (int i = 0; i < 500 && glog.len() < 4; i++) @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_mem_req", 32'(mem_req), 0);
        chk("rst_mid_no_ready", {if_ready, d_ready}, 0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        chk("rst_mid_sticky_clr", 32'(err_sticky), 0);
      end
    join
    chk("rst_regrant_order", (glog == "DDDDDDDDID") ? 1 : 0, 1);
    if (glog != "DDDDDDDDID") $display("  order was %s", glog);

    // ack on the same cycle the watchdog would fire
    fix_wait = 7;
    d_xfer(1'b0, 32'h160, '0, 4'hF, 1'b0, busy, bad);
    d_req = 1'b0;
    chk("tie_busy_cycles", busy, 8);
    chk("tie_sticky", 32'(err_sticky), 0);

    // random concurrent traffic
    rand_wait = 1'b1;
    fork
      begin
        int b5, x5;
        for (int k = 0; k < 40; k++) begin
          d_xfer(1'($urandom_range(0, 1)),
                 32'h100 + 32'(4 * $urandom_range(0, 15)),
                 $urandom, 4'($urandom_range(0, 15)), 1'b0, b5, x5);
          if ($urandom_range(0, 1) == 1) begin
            d_req = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clock);
            #1;
          end
        end
        d_req = 1'b0;
      end
      begin
        int b6, x6;
        for (int k = 0; k < 40; k++) begin
          f_xfer(32'(4 * $urandom_range(0, 63)), b6, x6);
          if ($urandom_range(0, 1) == 1) begin
            if_req = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clock);
            #1;
          end
        end
        if_req = 1'b0;
      end
    join

    repeat (4) @(negedge clock);
    chk("final_sticky", 32'(err_sticky), 0);
    chk("final_queues_empty", qi.size() + qd.size(), 0);
    chk("final_idle", 32'(mem_req), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory port between the instruction-fetch requester and the load/store requester.
- Grants one transaction at a time. Data has fixed priority over fetch, with a starvation guard for fetch.
- Drives a req/ack memory interface and adds a watchdog timeout for the memory side.
- Sits between the fetch stage and data path on one side, and the unified memory model on the other.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- MAX_DATA_STREAK, 4, maximum consecutive data grants while fetch is waiting; range 1..15.
- TIMEOUT_CYCLES, 64, cycles in a busy state without mem_ack before abort; 0 disables the watchdog; max 255.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_ready.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_ready  out  1  fetch transaction complete (this cycle).
- if_rdata  out  DATA_WIDTH  fetch read data, valid when if_ready.
- d_req  in  1  data request; held with d_we, d_addr, d_wdata, d_be stable until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_be  in  DATA_WIDTH/8  byte enables.
- d_ready  out  1  data transaction complete (this cycle).
- d_rdata  out  DATA_WIDTH  load data, valid when d_ready.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_be  out  DATA_WIDTH/8  memory byte enables.
- mem_ack  in  1  memory completes the current request this cycle.
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack.
- xfer_err  out  1  pulses with X_ready when a transaction is aborted by timeout.
- err_sticky  out  1  set on any timeout; cleared only by reset.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; streak=0; wdog=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
  - if_ready=0, d_ready=0, xfer_err=0, err_sticky=0.
  - Reset mid-transaction drops mem_req immediately; the in-flight transaction is lost and no ready is issued.
- States: IDLE, BUSY_IF, BUSY_D.
- All mem_* outputs are registered and loaded only on the IDLE->BUSY edge.
- IDLE arbitration, evaluated each rising edge:
  - If d_req and (!if_req or streak<MAX_DATA_STREAK): go to BUSY_D and latch the data fields into mem_*. If if_req is also high, streak+=1; otherwise streak=0.
  - Else if if_req: go to BUSY_IF; mem_addr=if_addr, mem_we=0, mem_be=all ones, mem_wdata=0; streak=0.
  - Else: stay in IDLE.
- mem_req=1 in BUSY_IF and BUSY_D; 0 in IDLE.
- Completion (combinational):
  - if_ready = (state==BUSY_IF) & (mem_ack | timeout).
  - d_ready = (state==BUSY_D) & (mem_ack | timeout).
  - if_rdata and d_rdata = mem_ack ? mem_rdata : 0.
  - xfer_err = timeout & !mem_ack.
- On completion the state returns to IDLE at the same edge. Minimum transaction length is 2 cycles: grant cycle, then ack cycle. Back-to-back grants are separated by one IDLE cycle.
- Requesters update or drop req at the edge where ready is seen. The arbiter never regrants a completed request because it re-samples only in IDLE.
- Watchdog:
  - wdog clears on entry to BUSY and increments each BUSY cycle without mem_ack.
  - timeout = (TIMEOUT_CYCLES!=0) & (wdog==TIMEOUT_CYCLES-1).
  - On timeout, err_sticky is set at the edge.
  - If mem_ack and timeout coincide, the ack wins: normal completion, no error.
- mem_ack while in IDLE is ignored.
- Requests that drop before being granted are ignored; no ready is issued.

Test Plan:
1. Single fetch: if_req=1, if_addr=0x40; mem_ack one cycle after mem_req rises with mem_rdata=0x8C220004 -> mem_addr=0x40, mem_we=0, if_ready=1 with if_rdata=0x8C220004 in the ack cycle; d_ready stays 0.
2. Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=0b0011; memory acks after 3 wait cycles -> mem_* carry exactly those values and are held stable 4 cycles; d_ready pulses once; d_rdata=0.
3. Starvation: if_req and d_req both held high continuously, acks immediate, MAX_DATA_STREAK=4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
4. Timeout: TIMEOUT_CYCLES=8, data load, mem_ack never asserted -> d_ready=1 and xfer_err=1 on the 8th BUSY cycle; mem_req falls next cycle; err_sticky=1 thereafter; next fetch completes normally.
5. Ack/timeout tie: mem_ack asserted exactly on the 8th BUSY cycle -> normal completion with rdata valid; xfer_err=0 and err_sticky=0.
6. Reset mid-op: reset_n low for one cycle while in BUSY_D -> mem_req=0 immediately with no clock edge; no d_ready; after release, the pending d_req is re-granted from IDLE with streak=0.
